nonce_hash_sequencer: RTL and testbench

- Sequences the shared SHA-256 compression core and the chunk decoder for one 80-byte block header.
- Compresses chunk1 (header bytes 0–63) once and saves the midstate.
- Then repeatedly compresses the padded chunk2 (header bytes 64–79), with the nonce field replaced by an internal counter, until the downstream comparator reports a hit or the nonce range is exhausted.

---
 rtl/mining_pkg.sv | 24 ++
 rtl/nonce_counter.sv | 33 +++
 rtl/nonce_hash_sequencer.sv | 152 +++++++++++++++
 tb/tb_nonce_hash_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mining_pkg.sv
// Shared types and constants for the block-header nonce search:
// sequencer states, decoder chunk selects and header/chunk widths.
package mining_pkg;

   localparam int HEADER_W = 640;
   localparam int CHUNK1_W = 512;
   localparam int CHUNK2_W = 128;
   localparam int NONCE_W  = 32;

   localparam logic [1:0] HASH_SEL_CHUNK1 = 2'd0;
   localparam logic [1:0] HASH_SEL_CHUNK2 = 2'd1;

   typedef enum logic [2:0] {
      IDLE,
      H1_START,
      H1_WAIT,
      H2_START,
      H2_WAIT,
      CHECK,
      FOUND,
      EXHAUST
   } seq_state_t;

endpackage

// File: rtl/nonce_counter.sv
// Nonce register: loads NONCE_START, increments on request and flags
// when the current value is the last one in the search range.
module nonce_counter
   import mining_pkg::*;
#(
   parameter logic [NONCE_W-1:0] NONCE_START = 32'h0000_0000,
   parameter logic [NONCE_W-1:0] NONCE_END   = 32'hFFFF_FFFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               incr,
   output logic [NONCE_W-1:0] nonce,
   output logic               last
);

   // NOTE: sequential state is written with <= only, so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         nonce <= NONCE_START;
      end else if (load) begin
         nonce <= NONCE_START;
      end else if (incr) begin
         nonce <= nonce + 1'b1;
      end
   end

   // The terminal compare is on the current value, so NONCE_END of all-ones
   // stops the search before the increment could wrap.
   assign last = (nonce == NONCE_END);

endmodule

// File: rtl/nonce_hash_sequencer.sv
// Drives the shared SHA-256 core and chunk decoder for one 80-byte header:
// chunk1 once to build the midstate, then chunk2 per nonce until hit or end.
module nonce_hash_sequencer
   import mining_pkg::*;
#(
   parameter logic [NONCE_W-1:0] NONCE_START = 32'h0000_0000,
   parameter logic [NONCE_W-1:0] NONCE_END   = 32'hFFFF_FFFF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                header_valid,
   input  logic [HEADER_W-1:0] header,
   output logic                busy,
   output logic [1:0]          hash_select,
   output logic [CHUNK1_W-1:0] chunk1,
   output logic [CHUNK2_W-1:0] chunk2,
   output logic                sha_start,
   output logic                sha_use_midstate,
   output logic                sha_save_midstate,
   input  logic                sha_done,
   output logic                digest_valid,
   input  logic                found,
   output logic [NONCE_W-1:0]  nonce,
   output logic                found_valid,
   output logic                exhausted
);

   seq_state_t state, next_state;

   logic [CHUNK2_W-NONCE_W-1:0] chunk2_hi;
   logic                        nonce_load;
   logic                        nonce_incr;
   logic                        nonce_last;

   // The header's own nonce field is always replaced by the counter.
   logic unused_header_nonce;
   assign unused_header_nonce = ^header[NONCE_W-1:0];

   nonce_counter #(
      .NONCE_START (NONCE_START),
      .NONCE_END   (NONCE_END)
   ) u_nonce_counter (
      .clk   (clk),
      .rst   (rst),
      .load  (nonce_load),
      .incr  (nonce_incr),
      .nonce (nonce),
      .last  (nonce_last)
   );

   assign chunk2 = {chunk2_hi, nonce};

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a latch behind.
   always_comb begin
      next_state        = state;
      busy              = 1'b0;
      sha_start         = 1'b0;
      sha_use_midstate  = 1'b0;
      sha_save_midstate = 1'b0;
      digest_valid      = 1'b0;
      found_valid       = 1'b0;
      exhausted         = 1'b0;
      nonce_load        = 1'b0;
      nonce_incr        = 1'b0;

      case (state)
         IDLE: begin
            if (header_valid) begin
               nonce_load = 1'b1;
               next_state = H1_START;
            end
         end
         H1_START: begin
            busy       = 1'b1;
            sha_start  = 1'b1;
            next_state = H1_WAIT;
         end
         H1_WAIT: begin
            busy = 1'b1;
            if (sha_done) begin
               sha_save_midstate = 1'b1;
               next_state        = H2_START;
            end
         end
         H2_START: begin
            busy             = 1'b1;
            sha_use_midstate = 1'b1;
            sha_start        = 1'b1;
            next_state       = H2_WAIT;
         end
         H2_WAIT: begin
            busy             = 1'b1;
            sha_use_midstate = 1'b1;
            if (sha_done) begin
               digest_valid = 1'b1;
               next_state   = CHECK;
            end
         end
         CHECK: begin
            busy             = 1'b1;
            sha_use_midstate = 1'b1;
            if (found) begin
               next_state = FOUND;
            end else if (nonce_last) begin
               next_state = EXHAUST;
            end else begin
               nonce_incr = 1'b1;
               next_state = H2_START;
            end
         end
         FOUND: begin
            found_valid = 1'b1;
            if (header_valid) begin
               nonce_load = 1'b1;
               next_state = H1_START;
            end
         end
         EXHAUST: begin
            exhausted = 1'b1;
            if (header_valid) begin
               nonce_load = 1'b1;
               next_state = H1_START;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // hash_select changes only on entry to a START state, so the decoder
   // input is steady from the start pulse until sha_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         chunk1      <= '0;
         chunk2_hi   <= '0;
         hash_select <= HASH_SEL_CHUNK1;
      end else begin
         state <= next_state;
         if (nonce_load) begin
            chunk1    <= header[HEADER_W-1 -: CHUNK1_W];
            chunk2_hi <= header[CHUNK2_W-1 : NONCE_W];
         end
         if (next_state == H1_START) begin
            hash_select <= HASH_SEL_CHUNK1;
         end else if (next_state == H2_START) begin
            hash_select <= HASH_SEL_CHUNK2;
         end
      end
   end

endmodule

// File: tb/tb_nonce_hash_sequencer.sv
// Self-checking bench: two sequencers (full range and a two-nonce range at
// the top of the 32-bit space) against a timeline model of the search.
module tb_nonce_hash_sequencer;
   import mining_pkg::*;

   localparam logic [31:0] S0 = 32'h0000_0000;
   localparam logic [31:0] E0 = 32'hFFFF_FFFF;
   localparam logic [31:0] S1 = 32'hFFFF_FFFE;
   localparam logic [31:0] E1 = 32'hFFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst;
   logic [639:0] header;
   logic         header_valid [2];
   logic         sha_done     [2];
   logic         found        [2];

   logic         busy              [2];
   logic [1:0]   hash_select       [2];
   logic [511:0] chunk1            [2];
   logic [127:0] chunk2            [2];
   logic         sha_start         [2];
   logic         sha_use_midstate  [2];
   logic         sha_save_midstate [2];
   logic         digest_valid      [2];
   logic [31:0]  nonce             [2];
   logic         found_valid       [2];
   logic         exhausted         [2];

   always #5 clk = ~clk;

   nonce_hash_sequencer #(.NONCE_START(S0), .NONCE_END(E0)) dut0 (
      .clk(clk), .rst(rst), .header_valid(header_valid[0]), .header(header),
      .busy(busy[0]), .hash_select(hash_select[0]), .chunk1(chunk1[0]),
      .chunk2(chunk2[0]), .sha_start(sha_start[0]),
      .sha_use_midstate(sha_use_midstate[0]),
      .sha_save_midstate(sha_save_midstate[0]), .sha_done(sha_done[0]),
      .digest_valid(digest_valid[0]), .found(found[0]), .nonce(nonce[0]),
      .found_valid(found_valid[0]), .exhausted(exhausted[0]));

   nonce_hash_sequencer #(.NONCE_START(S1), .NONCE_END(E1)) dut1 (
      .clk(clk), .rst(rst), .header_valid(header_valid[1]), .header(header),
      .busy(busy[1]), .hash_select(hash_select[1]), .chunk1(chunk1[1]),
      .chunk2(chunk2[1]), .sha_start(sha_start[1]),
      .sha_use_midstate(sha_use_midstate[1]),
      .sha_save_midstate(sha_save_midstate[1]), .sha_done(sha_done[1]),
      .digest_valid(digest_valid[1]), .found(found[1]), .nonce(nonce[1]),
      .found_valid(found_valid[1]), .exhausted(exhausted[1]));

   // ---------------- model state ----------------
   typedef struct {
      logic         busy;
      logic [1:0]   hs;
      logic [511:0] c1;
      logic [127:0] c2;
      logic         st, um, sm, dv;
      logic [31:0]  nonce;
      logic         fv, ex;
   } exp_t;

   longint       cyc = 0;
   int           lat = 64;         // core latency, start cycle to done cycle
   bit           chk_en = 0;
   bit           m_act [2];
   longint       m_a   [2];        // cycle header_valid was accepted
   longint       m_T   [2];        // nonce the comparator hits on, -1 = none
   longint       m_L   [2];
   logic [639:0] m_hdr [2];
   longint       p_T   [2];        // target for the next accepted header
   longint       done_at [2];
   int           start_cnt [2];
   int           save_cnt  [2];
   int           dv_cnt    [2];
   logic [1:0]   sel_log [$];
   int           errors = 0;
   int           checks = 0;

   task automatic check(input string nm, input logic [639:0] got, input logic [639:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   function automatic longint range_lo(int i);
      return (i == 0) ? {32'd0, S0} : {32'd0, S1};
   endfunction
   function automatic longint range_hi(int i);
      return (i == 0) ? {32'd0, E0} : {32'd0, E1};
   endfunction

   // Expected outputs at cycle c from the accept cycle, the core latency and
   // the nonce count: H1 takes L+1 cycles, each chunk2 nonce takes L+2.
   function automatic exp_t model_at(int i, longint c);
      exp_t   x;
      longint s, e, t, u, k, idx, n, nv;
      bit     hit;
      s = range_lo(i);
      e = range_hi(i);
      x = '{busy:1'b0, hs:2'd0, c1:m_hdr[i][639:128], c2:'0, st:1'b0, um:1'b0,
            sm:1'b0, dv:1'b0, nonce:s[31:0], fv:1'b0, ex:1'b0};
      nv = s;
      if (m_act[i]) begin
         hit = (m_T[i] >= s) && (m_T[i] <= e);
         n   = hit ? (m_T[i] - s + 1) : (e - s + 1);
         t   = c - (m_a[i] + 1);
         if (t == 0) begin
            x.busy = 1'b1;
            x.st   = 1'b1;
         end else if (t <= m_L[i]) begin
            x.busy = 1'b1;
            x.sm   = (t == m_L[i]);
         end else begin
            u   = t - (m_L[i] + 1);
            idx = u / (m_L[i] + 2);
            k   = u % (m_L[i] + 2);
            x.hs = 2'd1;
            if (idx >= n) begin
               nv   = s + n - 1;
               x.fv = hit;
               x.ex = !hit;
            end else begin
               nv     = s + idx;
               x.busy = 1'b1;
               x.um   = 1'b1;
               x.st   = (k == 0);
               x.dv   = (k == m_L[i]);
            end
         end
      end
      x.nonce = nv[31:0];
      x.c2    = {m_hdr[i][127:32], x.nonce};
      return x;
   endfunction

   // Comparator verdict: high in the CHECK cycle of the target nonce only.
   function automatic logic model_found(int i, longint c);
      longint s, t, u, idx, k;
      logic   r;
      r = 1'b0;
      s = range_lo(i);
      if (m_act[i] && m_T[i] >= s && m_T[i] <= range_hi(i)) begin
         t = c - (m_a[i] + 1);
         if (t > m_L[i]) begin
            u   = t - (m_L[i] + 1);
            idx = u / (m_L[i] + 2);
            k   = u % (m_L[i] + 2);
            r   = (k == m_L[i] + 1) && (s + idx == m_T[i]);
         end
      end
      return r;
   endfunction

   // Input driver: core done pulses and comparator verdicts, #1 after the edge.
   initial begin
      for (int i = 0; i < 2; i++) begin
         sha_done[i] = 1'b0;
         found[i]    = 1'b0;
      end
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         for (int i = 0; i < 2; i++) begin
            sha_done[i] = (cyc == done_at[i]);
            found[i]    = model_found(i, cyc);
         end
      end
   end

   // Compare process: every cycle, every output of both instances.
   always @(negedge clk) begin
      exp_t x;
      for (int i = 0; i < 2; i++) begin
         x = model_at(i, cyc);
         if (chk_en) begin
            check($sformatf("i%0d busy", i), busy[i], x.busy);
            check($sformatf("i%0d hash_select", i), hash_select[i], x.hs);
            check($sformatf("i%0d chunk1", i), chunk1[i], x.c1);
            check($sformatf("i%0d chunk2", i), chunk2[i], x.c2);
            check($sformatf("i%0d sha_start", i), sha_start[i], x.st);
            check($sformatf("i%0d use_midstate", i), sha_use_midstate[i], x.um);
            check($sformatf("i%0d save_midstate", i), sha_save_midstate[i], x.sm);
            check($sformatf("i%0d digest_valid", i), digest_valid[i], x.dv);
            check($sformatf("i%0d nonce", i), nonce[i], x.nonce);
            check($sformatf("i%0d found_valid", i), found_valid[i], x.fv);
            check($sformatf("i%0d exhausted", i), exhausted[i], x.ex);
         end
         if (sha_start[i] === 1'b1) begin
            done_at[i] = cyc + lat;
            start_cnt[i]++;
            if (i == 0) sel_log.push_back(hash_select[0]);
         end
         if (sha_save_midstate[i] === 1'b1) save_cnt[i]++;
         if (digest_valid[i] === 1'b1) dv_cnt[i]++;
         if (rst) begin
            m_act[i] = 1'b0;
            m_hdr[i] = '0;
         end else if (header_valid[i] && !x.busy) begin
            m_act[i] = 1'b1;
            m_a[i]   = cyc;
            m_T[i]   = p_T[i];
            m_L[i]   = lat;
            m_hdr[i] = header;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_counts();
      for (int i = 0; i < 2; i++) begin
         start_cnt[i] = 0;
         save_cnt[i]  = 0;
         dv_cnt[i]    = 0;
      end
      sel_log.delete();
   endtask

   task automatic send(input int i, input logic [639:0] h);
      @(posedge clk); #1;
      header          = h;
      header_valid[i] = 1'b1;
      @(posedge clk); #1;
      header_valid[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(found_valid[i] === 1'b1 || exhausted[i] === 1'b1) && n < budget);
      if (!(found_valid[i] === 1'b1 || exhausted[i] === 1'b1)) begin
         checks++;
         errors++;
         $display("FAIL i%0d timeout: no found_valid/exhausted after %0d cycles", i, budget);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [639:0] rand_header();
      logic [639:0] h;
      for (int w = 0; w < 20; w++) h[w*32 +: 32] = $urandom;
      return h;
   endfunction

   initial begin
      logic [639:0] h1, h2;
      int           n;
      rst    = 1'b1;
      header = '0;
      for (int i = 0; i < 2; i++) begin
         header_valid[i] = 1'b0;
         m_act[i] = 1'b0;
         m_hdr[i] = '0;
         m_T[i]   = -1;
         p_T[i]   = -1;
         m_L[i]   = 2;
         m_a[i]   = 0;
         done_at[i] = -1;
      end
      clear_counts();
      @(posedge clk); #1;
      chk_en = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check("reset busy", busy[0], 1'b0);
      check("reset nonce1", nonce[1], S1);
      check("reset chunk1", chunk1[0], 512'd0);

      // Hit on the first nonce, 64-cycle core.
      for (int b = 0; b < 80; b++) h1[639 - 8*b -: 8] = 8'(b + 1);
      lat    = 64;
      p_T[0] = 0;
      clear_counts();
      send(0, h1);
      wait_done(0, 1000);
      check("t1 starts", start_cnt[0], 2);
      check("t1 saves", save_cnt[0], 1);
      check("t1 sel count", sel_log.size(), 2);
      if (sel_log.size() >= 2) begin
         check("t1 sel first", sel_log[0], HASH_SEL_CHUNK1);
         check("t1 sel second", sel_log[1], HASH_SEL_CHUNK2);
      end
      check("t1 found_valid", found_valid[0], 1'b1);
      check("t1 nonce", nonce[0], 32'h0);
      check("t1 chunk1", chunk1[0], 512'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f40);

      // Restart from FOUND, hit on the 5th nonce, header_valid while busy.
      lat    = 8;
      p_T[0] = 4;
      h2     = rand_header();
      clear_counts();
      send(0, h2);
      @(negedge clk);
      check("t2 found_valid cleared", found_valid[0], 1'b0);
      check("t2 restart nonce", nonce[0], 32'h0);
      idle(15);
      send(0, ~h2);
      wait_done(0, 500);
      check("t2 starts", start_cnt[0], 6);
      check("t2 nonce", nonce[0], 32'h4);
      check("t2 chunk2 low", chunk2[0][31:0], 32'h4);
      check("t2 chunk1 kept", chunk1[0], h2[639:128]);

      // Spurious sha_done while idle.
      done_at[1] = cyc + 2;
      idle(5);
      check("spurious busy", busy[1], 1'b0);
      check("spurious digests", dv_cnt[1], 0);

      // Exhaustion at the top of the nonce space.
      lat    = 5;
      p_T[1] = -1;
      clear_counts();
      send(1, rand_header());
      wait_done(1, 500);
      check("t3 chunk2 hashes", start_cnt[1] - 1, 2);
      check("t3 exhausted", exhausted[1], 1'b1);
      check("t3 nonce", nonce[1], 32'hFFFF_FFFF);
      check("t3 found_valid", found_valid[1], 1'b0);

      // Reset during H2_WAIT of nonce 3; the core's late done must be ignored.
      lat    = 6;
      p_T[0] = 100;
      send(0, rand_header());
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(nonce[0] == 32'd3 && sha_use_midstate[0] && !sha_start[0]) && n < 200);
      check("t4 reached nonce 3", nonce[0], 32'd3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_counts();
      @(negedge clk);
      check("t4 busy", busy[0], 1'b0);
      check("t4 nonce", nonce[0], 32'h0);
      check("t4 chunk2", chunk2[0], 128'd0);
      check("t4 hash_select", hash_select[0], HASH_SEL_CHUNK1);
      idle(lat + 4);
      check("t4 stray digest", dv_cnt[0], 0);

      // Randomised runs over both instances.
      repeat (14) begin
         int i, pick;
         i    = $urandom_range(0, 1);
         lat  = $urandom_range(2, 9);
         pick = $urandom_range(0, 2);
         if (i == 0) p_T[0] = $urandom_range(0, 6);
         else p_T[1] = (pick == 0) ? -1 : (pick == 1) ? range_lo(1) : range_hi(1);
         send(i, rand_header());
         wait_done(i, 500);
         idle($urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
